// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection,
// flush-driven bubble insertion and a saturating bubble counter.
module id_ex_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        MemToRegD,
  input  logic        ALUSrcD,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic [1:0]  ALUOpD,
  input  logic [1:0]  ResultSrcD,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic [31:0] ImmExtD,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  input  logic [2:0]  funct3D,
  input  logic        funct7b5D,
  input  logic        ValidD,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        MemToRegE,
  output logic        ALUSrcE,
  output logic        BranchE,
  output logic        JumpE,
  output logic [1:0]  ALUOpE,
  output logic [1:0]  ResultSrcE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [2:0]  funct3E,
  output logic        funct7b5E,
  output logic        ValidE,
  output logic        StallF,
  output logic        StallD,
  output logic [15:0] BubbleCnt
);

  logic lw_haz;
  logic bubble;
  logic ctrl_ok;
  logic data_ok;

  assign lw_haz = ValidE & ValidD & (ResultSrcE == 2'b01) &
                  (RdE != 5'd0) &
                  ((RdE == Rs1D) | (RdE == Rs2D));

  // A flushed D instruction is discarded anyway, so no stall is needed.
  assign StallF  = lw_haz & ~FlushE;
  assign StallD  = lw_haz & ~FlushE;
  assign bubble  = FlushE | lw_haz;
  assign ctrl_ok = ValidD & ~bubble;
  assign data_ok = ~bubble;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteE  <= 1'b0;
      MemWriteE  <= 1'b0;
      MemToRegE  <= 1'b0;
      ALUSrcE    <= 1'b0;
      BranchE    <= 1'b0;
      JumpE      <= 1'b0;
      ALUOpE     <= 2'b00;
      ResultSrcE <= 2'b00;
      RD1E       <= 32'd0;
      RD2E       <= 32'd0;
      PCE        <= 32'd0;
      PCPlus4E   <= 32'd0;
      ImmExtE    <= 32'd0;
      Rs1E       <= 5'd0;
      Rs2E       <= 5'd0;
      RdE        <= 5'd0;
      funct3E    <= 3'd0;
      funct7b5E  <= 1'b0;
      ValidE     <= 1'b0;
      BubbleCnt  <= 16'd0;
    end else begin
      RegWriteE  <= RegWriteD & ctrl_ok;
      MemWriteE  <= MemWriteD & ctrl_ok;
      MemToRegE  <= MemToRegD & ctrl_ok;
      ALUSrcE    <= ALUSrcD & ctrl_ok;
      BranchE    <= BranchD & ctrl_ok;
      JumpE      <= JumpD & ctrl_ok;
      ALUOpE     <= ALUOpD & {2{ctrl_ok}};
      ResultSrcE <= ResultSrcD & {2{ctrl_ok}};
      ValidE     <= ctrl_ok;
      // Data of an invalid slot passes through; only bubbles zero it.
      RD1E       <= RD1D & {32{data_ok}};
      RD2E       <= RD2D & {32{data_ok}};
      PCE        <= PCD & {32{data_ok}};
      PCPlus4E   <= PCPlus4D & {32{data_ok}};
      ImmExtE    <= ImmExtD & {32{data_ok}};
      Rs1E       <= Rs1D & {5{data_ok}};
      Rs2E       <= Rs2D & {5{data_ok}};
      RdE        <= RdD & {5{data_ok}};
      funct3E    <= funct3D & {3{data_ok}};
      funct7b5E  <= funct7b5D & data_ok;
      if (bubble && (BubbleCnt != 16'hFFFF))
        BubbleCnt <= BubbleCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: vector table with a
// scoreboard queue, plus reset and counter-saturation sequences.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteD, MemWriteD, MemToRegD, ALUSrcD;
  logic        BranchD, JumpD;
  logic [1:0]  ALUOpD, ResultSrcD;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [2:0]  funct3D;
  logic        funct7b5D, ValidD, FlushE;
  logic        RegWriteE, MemWriteE, MemToRegE, ALUSrcE;
  logic        BranchE, JumpE;
  logic [1:0]  ALUOpE, ResultSrcE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [2:0]  funct3E;
  logic        funct7b5E, ValidE, StallF, StallD;
  logic [15:0] BubbleCnt;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .MemToRegD(MemToRegD), .ALUSrcD(ALUSrcD),
    .BranchD(BranchD), .JumpD(JumpD),
    .ALUOpD(ALUOpD), .ResultSrcD(ResultSrcD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .funct3D(funct3D), .funct7b5D(funct7b5D),
    .ValidD(ValidD), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .MemToRegE(MemToRegE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE),
    .ALUOpE(ALUOpE), .ResultSrcE(ResultSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .funct3E(funct3E), .funct7b5E(funct7b5E),
    .ValidE(ValidE), .StallF(StallF), .StallD(StallD),
    .BubbleCnt(BubbleCnt)
  );

  // ctrl = {RegWrite,MemWrite,MemToReg,ALUSrc,Branch,Jump,ALUOp,ResultSrc}
  localparam logic [9:0] C_R  = 10'b1000001000;
  localparam logic [9:0] C_LW = 10'b1011000001;
  localparam logic [9:0] C_SW = 10'b0101000000;
  localparam logic [9:0] C_BQ = 10'b0000100100;
  localparam logic [9:0] C_0  = 10'b0000000000;

  typedef struct {
    logic [9:0]  ctrl;
    logic [31:0] rd1;
    logic [4:0]  rs1, rs2, rd;
    logic        valid, flush;
    logic        e_stall, e_valid;
    logic [9:0]  e_ctrl;
    logic        e_pass;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic        valid;
    logic [9:0]  ctrl;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [15:0] cnt;
  } exp_t;

  int tests = 0;
  int fails = 0;
  vec_t vecs[17];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [9:0] c, input logic [31:0] d1,
    input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
    input logic v, input logic f, input logic es, input logic ev,
    input logic [9:0] ec, input logic ep, input logic [15:0] en);
    vec_t t;
    t.ctrl = c; t.rd1 = d1; t.rs1 = s1; t.rs2 = s2; t.rd = d;
    t.valid = v; t.flush = f; t.e_stall = es; t.e_valid = ev;
    t.e_ctrl = ec; t.e_pass = ep; t.e_cnt = en;
    return t;
  endfunction

  function automatic logic [9:0] ctrl_e();
    return {RegWriteE, MemWriteE, MemToRegE, ALUSrcE, BranchE,
            JumpE, ALUOpE, ResultSrcE};
  endfunction

  task automatic drive(input vec_t v);
    {RegWriteD, MemWriteD, MemToRegD, ALUSrcD, BranchD, JumpD,
     ALUOpD, ResultSrcD} = v.ctrl;
    RD1D = v.rd1;
    RD2D = v.rd1 ^ 32'h5A5A0000;
    PCD = v.rd1 + 32'h100;
    PCPlus4D = v.rd1 + 32'h104;
    ImmExtD = ~v.rd1;
    Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd;
    funct3D = v.valid ? v.rd[2:0] : 3'd0;
    funct7b5D = v.valid ? v.rd[0] : 1'b0;
    ValidD = v.valid;
    FlushE = v.flush;
  endtask

  task automatic push_exp(input int i, input vec_t v);
    exp_t e;
    e.idx = i;
    e.valid = v.e_valid;
    e.ctrl = v.e_ctrl;
    e.rd1 = v.e_pass ? RD1D : 32'd0;
    e.rd2 = v.e_pass ? RD2D : 32'd0;
    e.pc  = v.e_pass ? PCD : 32'd0;
    e.pc4 = v.e_pass ? PCPlus4D : 32'd0;
    e.imm = v.e_pass ? ImmExtD : 32'd0;
    e.rs1 = v.e_pass ? Rs1D : 5'd0;
    e.rs2 = v.e_pass ? Rs2D : 5'd0;
    e.rd  = v.e_pass ? RdD : 5'd0;
    e.f3  = v.e_pass ? funct3D : 3'd0;
    e.f7  = v.e_pass ? funct7b5D : 1'b0;
    e.cnt = v.e_cnt;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    string n;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    n = $sformatf("v%0d", e.idx);
    chk({n, "_ValidE"}, 32'(ValidE), 32'(e.valid));
    chk({n, "_ctrlE"}, 32'(ctrl_e()), 32'(e.ctrl));
    chk({n, "_RD1E"}, RD1E, e.rd1);
    chk({n, "_RD2E"}, RD2E, e.rd2);
    chk({n, "_PCE"}, PCE, e.pc);
    chk({n, "_PCPlus4E"}, PCPlus4E, e.pc4);
    chk({n, "_ImmExtE"}, ImmExtE, e.imm);
    chk({n, "_idxE"}, 32'({Rs1E, Rs2E, RdE}),
        32'({e.rs1, e.rs2, e.rd}));
    chk({n, "_functE"}, 32'({funct3E, funct7b5E}),
        32'({e.f3, e.f7}));
    chk({n, "_BubbleCnt"}, 32'(BubbleCnt), 32'(e.cnt));
  endtask

  initial begin
    //          ctrl  rd1       s1  s2  rd  v  f  st ev ectrl pass cnt
    vecs[0]  = mk(C_R,  32'h11, 1,  2,  5,  1, 0, 0, 1, C_R,  1, 0);
    vecs[1]  = mk(C_LW, 32'h20, 5,  0,  7,  1, 0, 0, 1, C_LW, 1, 0);
    vecs[2]  = mk(C_R,  32'h33, 7,  3,  8,  1, 0, 1, 0, C_0,  0, 1);
    vecs[3]  = mk(C_R,  32'h33, 7,  3,  8,  1, 0, 0, 1, C_R,  1, 1);
    vecs[4]  = mk(C_LW, 32'h44, 2,  0,  0,  1, 0, 0, 1, C_LW, 1, 1);
    vecs[5]  = mk(C_R,  32'h55, 0,  0,  9,  1, 0, 0, 1, C_R,  1, 1);
    vecs[6]  = mk(C_LW, 32'h66, 1,  0,  10, 1, 0, 0, 1, C_LW, 1, 1);
    vecs[7]  = mk(C_SW, 32'h77, 4,  10, 0,  1, 1, 0, 0, C_0,  0, 2);
    vecs[8]  = mk(C_BQ, 32'h88, 10, 1,  3,  0, 0, 0, 0, C_0,  1, 2);
    vecs[9]  = mk(C_LW, 32'h99, 6,  0,  12, 1, 0, 0, 1, C_LW, 1, 2);
    vecs[10] = mk(C_R,  32'hAA, 12, 1,  13, 0, 0, 0, 0, C_0,  1, 2);
    vecs[11] = mk(C_R,  32'hBB, 1,  2,  14, 1, 1, 0, 0, C_0,  0, 3);
    vecs[12] = mk(C_R,  32'hCC, 1,  2,  15, 1, 0, 0, 1, C_R,  1, 3);
    vecs[13] = mk(C_LW, 32'hDD, 3,  0,  16, 1, 0, 0, 1, C_LW, 1, 3);
    vecs[14] = mk(C_R,  32'hEE, 1,  16, 17, 1, 0, 1, 0, C_0,  0, 4);
    vecs[15] = mk(C_R,  32'hEE, 1,  16, 17, 1, 0, 0, 1, C_R,  1, 4);
    vecs[16] = mk(C_LW, 32'hF0, 2,  0,  20, 1, 0, 0, 1, C_LW, 1, 4);

    reset = 1'b1;
    drive(mk(C_R, 32'hDEAD, 1, 2, 3, 1, 0, 0, 0, C_0, 0, 0));
    @(posedge clk); #1;
    chk("rst_ValidE", 32'(ValidE), 32'd0);
    chk("rst_ctrlE", 32'(ctrl_e()), 32'd0);
    chk("rst_RD1E", RD1E, 32'd0);
    chk("rst_BubbleCnt", 32'(BubbleCnt), 32'd0);
    chk("rst_Stall", 32'({StallF, StallD}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_StallF", i), 32'(StallF),
          32'(vecs[i].e_stall));
      chk($sformatf("v%0d_StallD", i), 32'(StallD),
          32'(vecs[i].e_stall));
      push_exp(i, vecs[i]);
      @(posedge clk); #1;
      pop_cmp();
      @(negedge clk);
    end

    // Load in E, dependent op in D, then reset between edges.
    drive(mk(C_R, 32'h1, 20, 0, 21, 1, 0, 0, 0, C_0, 0, 0));
    #1;
    chk("pre_rst_StallD", 32'(StallD), 32'd1);
    chk("pre_rst_ValidE", 32'(ValidE), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_ValidE", 32'(ValidE), 32'd0);
    chk("async_RegWriteE", 32'(RegWriteE), 32'd0);
    chk("async_BubbleCnt", 32'(BubbleCnt), 32'd0);
    chk("async_StallD", 32'(StallD), 32'd0);
    @(posedge clk); #1;
    chk("held_ValidE", 32'(ValidE), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(mk(C_R, 32'h1234, 1, 2, 21, 1, 0, 0, 0, C_0, 0, 0));
    @(posedge clk); #1;
    chk("post_rst_ValidE", 32'(ValidE), 32'd1);
    chk("post_rst_RD1E", RD1E, 32'h1234);
    chk("post_rst_RdE", 32'(RdE), 32'd21);
    chk("post_rst_BubbleCnt", 32'(BubbleCnt), 32'd0);

    @(negedge clk);
    FlushE = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_FFFE", 32'(BubbleCnt), 32'hFFFE);
    @(posedge clk); #1;
    chk("sat_FFFF", 32'(BubbleCnt), 32'hFFFF);
    @(posedge clk); #1;
    chk("sat_65536", 32'(BubbleCnt), 32'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    chk("sat_hold", 32'(BubbleCnt), 32'hFFFF);
    chk("sat_ValidE", 32'(ValidE), 32'd0);
    chk("sat_RegWriteE", 32'(RegWriteE), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
